pll_div_ratio_checker: RTL and testbench

- Verifies a PLL's divided outputs (DIV2, DIV3, DIV4) against its primary output.
- Runs in the PLL CLK_OUT domain; that clock is the block's `clk`.
- Each divided clock arrives as a level sample, `div_smp[i]`, already registered in `clk`.
- Over a fixed measurement window the block counts rising edges per channel, compares each count with the ideal ratio, and reports pass/fail per channel plus a sticky error.

---
 rtl/pll_chk_pkg.sv | 19 +
 rtl/pll_edge_counter.sv | 68 ++++++
 rtl/pll_div_ratio_checker.sv | 105 ++++++++++
 tb/tb_pll_div_ratio_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_chk_pkg.sv
// Shared types and constants for the PLL divider ratio checker.
package pll_chk_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Channel i watches a divide-by-(i + DIV_BASE) clock.
    localparam int DIV_BASE = 2;

    // Ideal number of rising edges of a divide-by-div clock over window cycles.
    function automatic int exp_count(input int window, input int div);
        return window / div;
    endfunction

endpackage

// File: rtl/pll_edge_counter.sv
// One monitored channel: rising-edge detect, saturating edge counter,
// tolerance compare against the ideal count and the reported result.
module pll_edge_counter #(
    parameter int CW  = 9,
    parameter int EXP = 128,
    parameter int TOL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_smp,
    input  logic          i_clear,
    input  logic          i_count_en,
    input  logic          i_report,
    output logic [CW-1:0] o_cnt,
    output logic          o_pass,
    output logic          o_pass_new
);

    localparam logic signed [CW:0] EXP_V = (CW + 1)'(EXP);
    localparam logic signed [CW:0] TOL_V = (CW + 1)'(TOL);

    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_edge_cnt;
    logic          r_pass;
    logic          w_rise;
    logic signed [CW:0] w_diff;

    assign w_rise = i_smp & ~r_prev;

    // One extra bit keeps the signed difference from wrapping for any count.
    assign w_diff     = $signed({1'b0, r_cnt}) - EXP_V;
    assign o_pass_new = (w_diff <= TOL_V) && (w_diff >= -TOL_V);

    // Previous sample register runs in every state so the first window cycle
    // already sees a valid history.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_smp;
    end

    // Saturating rising-edge counter, cleared whenever no window is running.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_count_en && w_rise && (r_cnt != '1))
            r_cnt <= r_cnt + CW'(1);
    end

    // Capture the final count and verdict; held until the next report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= '0;
            r_pass     <= 1'b0;
        end else if (i_report) begin
            r_edge_cnt <= r_cnt;
            r_pass     <= o_pass_new;
        end
    end

    assign o_cnt  = r_edge_cnt;
    assign o_pass = r_pass;

endmodule

// File: rtl/pll_div_ratio_checker.sv
// Measures edge counts of the PLL's divided clocks over a fixed window of
// CLK_OUT cycles and flags channels whose ratio is outside tolerance.
module pll_div_ratio_checker
    import pll_chk_pkg::*;
#(
    parameter  int WINDOW = 256,
    parameter  int NUM_CH = 3,
    parameter  int TOL    = 1,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    div_smp,
    input  logic                 clear_err,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CH-1:0]    pass,
    output logic [NUM_CH*CW-1:0] edge_cnt,
    output logic                 err_sticky
);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_win_cnt;
    logic            r_done;
    logic            r_err;
    logic            w_count_en;
    logic            w_report;
    logic            w_clear;
    logic [NUM_CH-1:0] w_pass_new;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; start during a window is simply not looked at.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start || continuous) w_next = MEASURE;
            MEASURE: if (r_win_cnt == CW'(WINDOW - 1)) w_next = REPORT;
            REPORT:  w_next = continuous ? MEASURE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded controls; counters sit cleared outside MEASURE so every
    // window, including back-to-back ones, starts from zero.
    always_comb begin
        w_count_en = (r_state == MEASURE);
        w_report   = (r_state == REPORT);
        w_clear    = (r_state != MEASURE);
    end

    // Window length counter.
    always_ff @(posedge clk) begin
        if (rst || w_clear) r_win_cnt <= '0;
        else                r_win_cnt <= r_win_cnt + CW'(1);
    end

    // Done pulse lands in the same cycle as the registered results.
    always_ff @(posedge clk) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= w_report;
    end

    // Sticky error: a new failure takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_report && !(&w_pass_new))
            r_err <= 1'b1;
        else if (clear_err)
            r_err <= 1'b0;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_edge_counter #(
            .CW  (CW),
            .EXP (exp_count(WINDOW, g + DIV_BASE)),
            .TOL (TOL)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .i_smp      (div_smp[g]),
            .i_clear    (w_clear),
            .i_count_en (w_count_en),
            .i_report   (w_report),
            .o_cnt      (edge_cnt[g*CW +: CW]),
            .o_pass     (pass[g]),
            .o_pass_new (w_pass_new[g])
        );
    end

    assign busy       = w_count_en;
    assign done       = r_done;
    assign err_sticky = r_err;

endmodule

// File: tb/tb_pll_div_ratio_checker.sv
// Directed bench for pll_div_ratio_checker with hand-derived expectations.
module tb_pll_div_ratio_checker;

    localparam int WINDOW = 256;
    localparam int NUM_CH = 3;
    localparam int TOL    = 1;
    localparam int CW     = $clog2(WINDOW + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 continuous;
    logic [NUM_CH-1:0]    div_smp;
    logic                 clear_err;
    logic                 busy;
    logic                 done;
    logic [NUM_CH-1:0]    pass;
    logic [NUM_CH*CW-1:0] edge_cnt;
    logic                 err_sticky;

    int checks = 0;
    int errors = 0;
    int gcyc   = 0;
    int per [NUM_CH];

    pll_div_ratio_checker #(
        .WINDOW (WINDOW),
        .NUM_CH (NUM_CH),
        .TOL    (TOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .div_smp    (div_smp),
        .clear_err  (clear_err),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .edge_cnt   (edge_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Divided-clock model: period p is high for the first p/2 cycles; 0 = stuck low.
    task automatic drive_smp();
        for (int ch = 0; ch < NUM_CH; ch++)
            div_smp[ch] = (per[ch] == 0) ? 1'b0 : ((gcyc % per[ch]) < (per[ch] / 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        gcyc++;
        drive_smp();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int ch);
        return int'(edge_cnt[ch*CW +: CW]);
    endfunction

    // Pulses start, optionally re-pulses it mid-window, and returns the cycle
    // index (start cycle = 0) at which done is first seen.
    task automatic run_window(input int restart_at, output int lat, output logic found);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        found = done;
        while (!found && lat < WINDOW + 50) begin
            start = (lat == restart_at);
            tick();
            start = 1'b0;
            lat++;
            found = done;
        end
    endtask

    int   lat;
    logic found;
    int   dcyc [4];
    int   ndone;
    int   cyc;

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; clear_err = 1'b0;
        per[0] = 2; per[1] = 3; per[2] = 4;
        drive_smp();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        check("reset edge_cnt", edge_cnt, 0);
        check("reset err", err_sticky, 0);

        // 1: ideal stimulus; a start mid-window must not be queued
        run_window(50, lat, found);
        check("t1 done seen", found, 1);
        check("t1 latency", lat, WINDOW + 2);
        check("t1 cnt0", cnt_of(0), 128);
        check("t1 cnt1 85..86", (cnt_of(1) == 85) || (cnt_of(1) == 86), 1);
        check("t1 cnt2", cnt_of(2), 64);
        check("t1 pass", pass, 3'b111);
        check("t1 err", err_sticky, 0);
        check("t1 busy at done", busy, 0);
        tick();
        check("t1 done one cycle", done, 0);
        tick(); tick();
        check("t1 start not queued", busy, 0);

        // 2: channel 1 stuck low
        per[1] = 0;
        run_window(-1, lat, found);
        check("t2 done seen", found, 1);
        check("t2 cnt1", cnt_of(1), 0);
        check("t2 cnt0", cnt_of(0), 128);
        check("t2 pass", pass, 3'b101);
        check("t2 err", err_sticky, 1);

        // 3: channel 2 at period 3, then clear, then ideal rerun
        per[1] = 3; per[2] = 3;
        run_window(-1, lat, found);
        check("t3 done seen", found, 1);
        check("t3 cnt2 85..86", (cnt_of(2) == 85) || (cnt_of(2) == 86), 1);
        check("t3 pass", pass, 3'b011);
        check("t3 err", err_sticky, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t3 err cleared", err_sticky, 0);
        per[2] = 4;
        run_window(-1, lat, found);
        check("t3 rerun pass", pass, 3'b111);
        check("t3 rerun err", err_sticky, 0);

        // 4: reset in cycle 100 of MEASURE
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        check("t4 busy before rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4 busy", busy, 0);
        check("t4 pass", pass, 0);
        check("t4 edge_cnt", edge_cnt, 0);
        check("t4 done", done, 0);
        ndone = 0;
        for (int i = 0; i < WINDOW + 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("t4 no done", ndone, 0);

        // 5: continuous for three windows, stray start mid-window
        continuous = 1'b1;
        tick();
        cyc   = 1;
        ndone = 0;
        while (ndone < 3 && cyc < 4 * (WINDOW + 1)) begin
            start = (cyc == 60);
            tick();
            start = 1'b0;
            cyc++;
            if (done) begin
                dcyc[ndone] = cyc;
                ndone++;
            end
        end
        check("t5 three dones", ndone, 3);
        check("t5 first latency", dcyc[0], WINDOW + 2);
        check("t5 spacing 1", dcyc[1] - dcyc[0], WINDOW + 1);
        check("t5 spacing 2", dcyc[2] - dcyc[1], WINDOW + 1);
        check("t5 pass", pass, 3'b111);
        continuous = 1'b0;
        check("t5 busy in 4th window", busy, 1);
        found = 1'b0;
        for (int i = 0; i < WINDOW + 5 && !found; i++) begin
            tick();
            cyc++;
            found = done;
        end
        check("t5 4th done", found, 1);
        check("t5 4th spacing", cyc - dcyc[2], WINDOW + 1);
        tick(); tick();
        check("t5 back to idle", busy, 0);

        // 6: clear_err in the same cycle as a failing REPORT
        per[1] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (busy && lat < WINDOW + 10) begin
            tick();
            lat++;
        end
        check("t6 reached report", lat, WINDOW);
        check("t6 err before", err_sticky, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t6 done", done, 1);
        check("t6 pass", pass, 3'b101);
        check("t6 set wins", err_sticky, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
